// File: rtl/matmul_pkg.sv
// Shared constants and state encoding for the matrix-multiply sequencer,
// the APB slave and the PE array.
package matmul_pkg;

  localparam int unsigned DATA_WIDTH_DEF = 32;
  localparam int unsigned BUS_WIDTH_DEF  = 64;

  function automatic int unsigned calc_max_dim(input int unsigned data_w,
                                               input int unsigned bus_w);
    return bus_w / data_w;
  endfunction

  function automatic int unsigned calc_dim_w(input int unsigned max_dim);
    return $clog2(max_dim) + 1;
  endfunction

  localparam int unsigned MAX_DIM = calc_max_dim(DATA_WIDTH_DEF, BUS_WIDTH_DEF);
  localparam int unsigned DIM_W   = calc_dim_w(MAX_DIM);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    CLEAR = 3'd1,
    FEED  = 3'd2,
    DRAIN = 3'd3,
    WRITE = 3'd4
  } state_e;

endpackage

// File: rtl/matmul_ctrl_if.sv
// Control/status bundle between the APB register map (master) and the
// matmul sequencer (slave).
interface matmul_ctrl_if
  import matmul_pkg::*;
#(
  parameter int unsigned DIM_W = matmul_pkg::DIM_W
) ();

  logic             start_i;
  logic             abort_i;
  logic             stall_i;
  logic [DIM_W-1:0] dim_n_i;
  logic [DIM_W-1:0] dim_k_i;
  logic [DIM_W-1:0] dim_m_i;
  logic             a_rd_en_o;
  logic             b_rd_en_o;
  logic [DIM_W-1:0] k_idx_o;
  logic             pe_clear_o;
  logic             pe_valid_o;
  logic             res_we_o;
  logic [DIM_W-1:0] res_row_o;
  logic             busy_o;
  logic             done_o;
  logic             err_o;
  logic [31:0]      cycles_o;

  modport slave (
    input  start_i, abort_i, stall_i, dim_n_i, dim_k_i, dim_m_i,
    output a_rd_en_o, b_rd_en_o, k_idx_o, pe_clear_o, pe_valid_o,
           res_we_o, res_row_o, busy_o, done_o, err_o, cycles_o
  );

  modport master (
    output start_i, abort_i, stall_i, dim_n_i, dim_k_i, dim_m_i,
    input  a_rd_en_o, b_rd_en_o, k_idx_o, pe_clear_o, pe_valid_o,
           res_we_o, res_row_o, busy_o, done_o, err_o, cycles_o
  );

endinterface

// File: rtl/matmul_ctrl_down_counter.sv
// Loadable down-counter with hold and zero flag; one instance per
// sequencer phase. Hold wins over load and decrement.
module ctrl_down_counter
  import matmul_pkg::*;
#(
  parameter int unsigned WIDTH = 2
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             hold_i,
  input  logic             load_i,
  input  logic [WIDTH-1:0] load_val_i,
  input  logic             en_i,
  output logic [WIDTH-1:0] cnt_o,
  output logic             zero_o
);

  logic [WIDTH-1:0] cnt_q, cnt_d;

  // Next count: hold, load, or saturating decrement.
  always_comb begin
    cnt_d = cnt_q;
    if (!hold_i) begin
      if (load_i) begin
        cnt_d = load_val_i;
      end else if (en_i && (cnt_q != '0)) begin
        cnt_d = cnt_q - WIDTH'(1);
      end
    end
  end

  // Count register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o  = cnt_q;
  assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/matmul_ctrl.sv
// Matrix-multiply sequencer: CLEAR -> FEED -> DRAIN -> WRITE, with stall,
// abort and sticky busy/done/err status.
// Optional feature: define MATMUL_CTRL_CYCLE_CNT_EN to build the run
// cycle counter behind cycles_o (tied to 0 otherwise).
module matmul_ctrl
  import matmul_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int unsigned BUS_WIDTH  = BUS_WIDTH_DEF
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  matmul_ctrl_if.slave  bus
);

  localparam int unsigned MAX_D = calc_max_dim(DATA_WIDTH, BUS_WIDTH);
  localparam int unsigned DW    = calc_dim_w(MAX_D);
  // DRAIN needs room for N+M, up to twice the largest dimension.
  localparam int unsigned CW    = DW + 1;

  localparam logic [DW-1:0] ONE_D    = DW'(1);
  localparam logic [CW-1:0] ONE_C    = CW'(1);
  localparam logic [DW-1:0] MAX_D_V  = DW'(MAX_D);

  function automatic logic dim_ok(input logic [DW-1:0] d);
    return (d != '0) && (d <= MAX_D_V);
  endfunction

  state_e          state_q, state_d;
  logic [DW-1:0]   n_q, n_d, k_q, k_d, m_q, m_d;
  logic            done_q, done_d;
  logic            err_q, err_d;
  logic            pe_valid_q, pe_valid_d;
  logic            dims_ok;
  logic            rd_en;

  logic            feed_ld, feed_en, feed_zero;
  logic            drain_ld, drain_en, drain_zero;
  logic            write_ld, write_en, write_zero;
  logic [DW-1:0]   feed_val, feed_cnt;
  logic [CW-1:0]   drain_val, drain_cnt;
  logic [DW-1:0]   write_val, write_cnt;

  assign dims_ok = dim_ok(bus.dim_n_i) && dim_ok(bus.dim_k_i) && dim_ok(bus.dim_m_i);

  // Phase counters terminate at zero, so each is loaded with length-1;
  // k and row are recovered as (length-1) - remaining.
  ctrl_down_counter #(.WIDTH(DW)) u_feed_cnt (
    .clk_i(clk_i), .rst_ni(rst_ni), .hold_i(bus.stall_i),
    .load_i(feed_ld), .load_val_i(feed_val), .en_i(feed_en),
    .cnt_o(feed_cnt), .zero_o(feed_zero)
  );

  ctrl_down_counter #(.WIDTH(CW)) u_drain_cnt (
    .clk_i(clk_i), .rst_ni(rst_ni), .hold_i(bus.stall_i),
    .load_i(drain_ld), .load_val_i(drain_val), .en_i(drain_en),
    .cnt_o(drain_cnt), .zero_o(drain_zero)
  );

  ctrl_down_counter #(.WIDTH(DW)) u_write_cnt (
    .clk_i(clk_i), .rst_ni(rst_ni), .hold_i(bus.stall_i),
    .load_i(write_ld), .load_val_i(write_val), .en_i(write_en),
    .cnt_o(write_cnt), .zero_o(write_zero)
  );

  // Next-state, dimension latch, status flags and counter control.
  always_comb begin
    state_d   = state_q;
    n_d       = n_q;
    k_d       = k_q;
    m_d       = m_q;
    done_d    = done_q;
    err_d     = err_q;
    feed_ld   = 1'b0;
    feed_en   = 1'b0;
    drain_ld  = 1'b0;
    drain_en  = 1'b0;
    write_ld  = 1'b0;
    write_en  = 1'b0;
    feed_val  = k_q - ONE_D;
    drain_val = CW'(n_q) + CW'(m_q) - ONE_C;
    write_val = n_q - ONE_D;

    if (bus.abort_i) begin
      state_d = IDLE;
      done_d  = 1'b0;
    end else if (state_q == IDLE) begin
      if (bus.start_i) begin
        if (dims_ok) begin
          n_d     = bus.dim_n_i;
          k_d     = bus.dim_k_i;
          m_d     = bus.dim_m_i;
          done_d  = 1'b0;
          err_d   = 1'b0;
          state_d = CLEAR;
        end else begin
          err_d = 1'b1;
        end
      end
    end else begin
      if (bus.start_i) begin
        err_d = 1'b1;
      end
      if (!bus.stall_i) begin
        case (state_q)
          CLEAR: begin
            state_d = FEED;
            feed_ld = 1'b1;
          end
          FEED: begin
            if (feed_zero) begin
              state_d  = DRAIN;
              drain_ld = 1'b1;
            end else begin
              feed_en = 1'b1;
            end
          end
          DRAIN: begin
            if (drain_zero) begin
              state_d  = WRITE;
              write_ld = 1'b1;
            end else begin
              drain_en = 1'b1;
            end
          end
          WRITE: begin
            if (write_zero) begin
              state_d = IDLE;
              done_d  = 1'b1;
            end else begin
              write_en = 1'b1;
            end
          end
          default: state_d = IDLE;
        endcase
      end
    end
  end

  // Output decode from registered state/counters; strobes gated by stall.
  always_comb begin
    rd_en          = (state_q == FEED) && !bus.stall_i;
    pe_valid_d     = rd_en;
    bus.a_rd_en_o  = rd_en;
    bus.b_rd_en_o  = rd_en;
    bus.k_idx_o    = (state_q == FEED) ? (k_q - ONE_D - feed_cnt) : '0;
    bus.pe_clear_o = (state_q == CLEAR) && !bus.stall_i;
    bus.pe_valid_o = pe_valid_q;
    bus.res_we_o   = (state_q == WRITE) && !bus.stall_i;
    bus.res_row_o  = (state_q == WRITE) ? (n_q - ONE_D - write_cnt) : '0;
    bus.busy_o     = (state_q != IDLE);
    bus.done_o     = done_q;
    bus.err_o      = err_q;
  end

  // Sequencer state and status registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= IDLE;
      n_q        <= '0;
      k_q        <= '0;
      m_q        <= '0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
      pe_valid_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      n_q        <= n_d;
      k_q        <= k_d;
      m_q        <= m_d;
      done_q     <= done_d;
      err_q      <= err_d;
      pe_valid_q <= pe_valid_d;
    end
  end

`ifdef MATMUL_CTRL_CYCLE_CNT_EN
  logic        start_accept;
  logic [31:0] cyc_q, cyc_d;

  assign start_accept = (state_q == IDLE) && bus.start_i && !bus.abort_i && dims_ok;

  // Run cycle count: cleared on accepted start, counts every busy edge.
  always_comb begin
    cyc_d = cyc_q;
    if (state_q != IDLE) begin
      cyc_d = cyc_q + 32'd1;
    end else if (start_accept) begin
      cyc_d = '0;
    end
  end

  // Cycle count register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cyc_q <= '0;
    end else begin
      cyc_q <= cyc_d;
    end
  end

  assign bus.cycles_o = cyc_q;
`else
  assign bus.cycles_o = '0;
`endif

endmodule
